// File: rtl/qdec_cabac_pkg.sv
// ============================================================================
// Module      : qdec_cabac_pkg
// Description : Shared constants, types and helpers for the CABAC bitstream
//               front-end (EPB detection constants, byte type, clog2).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package qdec_cabac_pkg;

    // Emulation-prevention byte and the zero run that must precede it
    localparam logic [7:0] EPB_BYTE = 8'h03;
    localparam int         EPB_ZRUN = 2;

    typedef logic [7:0] bs_byte_t;

    // Ceiling log2 usable in constant expressions; clog2(1) = 0
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/qdec_bs_byte_fifo.sv
// ============================================================================
// Module      : qdec_bs_byte_fifo
// Description : Synchronous byte FIFO, power-of-two depth, wrap-around
//               pointers with an extra MSB for full/empty, sync clear.
//               Read data is presented combinationally from the head entry.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module qdec_bs_byte_fifo
    import qdec_cabac_pkg::*;
#(
    parameter int DEPTH = 16
)(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_clr,
    input  logic     i_push,
    input  bs_byte_t i_din,
    input  logic     i_pop,
    output bs_byte_t o_dout,
    output logic     o_full,
    output logic     o_empty
);

    localparam int c_aw = clog2(DEPTH);

    bs_byte_t          r_mem [DEPTH];
    logic [c_aw:0]     r_wr;
    logic [c_aw:0]     r_rd;

    assign o_empty = (r_wr == r_rd);
    assign o_full  = (r_wr[c_aw] != r_rd[c_aw]) && (r_wr[c_aw-1:0] == r_rd[c_aw-1:0]);
    assign o_dout  = r_mem[r_rd[c_aw-1:0]];

    // Storage array; a push while full is only issued together with a pop
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr[c_aw-1:0]] <= i_din;
        end
    end

    // Pointer update with clear taking priority over push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else if (i_clr) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + 1'b1;
            if (i_pop)  r_rd <= r_rd + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/qdec_bs_fetch.sv
// ============================================================================
// Module      : qdec_bs_fetch
// Description : CABAC bitstream front-end. Stages IN_BYTES-wide input beats,
//               strips 00 00 03 emulation-prevention bytes, buffers bytes in
//               a FIFO and presents an MSB-first bit window with variable
//               consume, byte-align and flush.
//               Optional: QDEC_BS_BYTECNT_EN adds stream_bytes / epb_count.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module qdec_bs_fetch
    import qdec_cabac_pkg::*;
#(
    parameter int IN_BYTES   = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_BITS   = 16,
    parameter int WIN_BITS   = 32
)(
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic [8*IN_BYTES-1:0]            bitstreamFetch,
    input  logic                             bitstreamFetch_vld,
    output logic                             bitstreamFetch_rdy,
    output logic [MAX_BITS-1:0]              bits_peek,
    output logic [clog2(WIN_BITS+1)-1:0]     bits_avail,
    input  logic [clog2(MAX_BITS+1)-1:0]     consume_len,
    input  logic                             consume_vld,
    output logic                             consume_rdy,
    input  logic                             align_req,
    output logic                             bytealign,
    output logic                             epb_dropped
`ifdef QDEC_BS_BYTECNT_EN
    ,
    output logic [31:0]                      stream_bytes,
    output logic [15:0]                      epb_count
`endif
);

    localparam int c_av_w  = clog2(WIN_BITS + 1);
    localparam int c_idx_w = (IN_BYTES > 1) ? clog2(IN_BYTES) : 1;

    // ---------------- staging / EPB filter ----------------
    logic [8*IN_BYTES-1:0] r_stg_data;
    logic                  r_stg_vld;
    logic [c_idx_w-1:0]    r_stg_idx;
    logic [1:0]            r_zcnt;
    logic                  r_epb;

    bs_byte_t w_cur_byte;
    logic     w_is_epb;
    logic     w_drain;
    logic     w_last;
    logic     w_beat_acc;

    // ---------------- FIFO ----------------
    bs_byte_t w_fifo_dout;
    logic     w_fifo_full;
    logic     w_fifo_empty;
    logic     w_fifo_push;
    logic     w_fifo_pop;

    // ---------------- window ----------------
    logic [WIN_BITS-1:0] r_win;
    logic [c_av_w-1:0]   r_avail;
    logic [2:0]          r_pos;

    logic                w_cons_fire;
    logic                w_align_fire;
    logic [c_av_w-1:0]   w_shift;
    logic [c_av_w-1:0]   w_avail_after;
    logic [WIN_BITS-1:0] w_win_after;
    logic [WIN_BITS-1:0] w_refill;

    assign bitstreamFetch_rdy = !r_stg_vld && !flush;
    assign w_beat_acc         = bitstreamFetch_vld && bitstreamFetch_rdy;

    assign w_cur_byte  = bs_byte_t'(r_stg_data >> {r_stg_idx, 3'b000});
    assign w_is_epb    = (r_zcnt == 2'(EPB_ZRUN)) && (w_cur_byte == EPB_BYTE);
    // A dropped EPB never needs FIFO space; a kept byte may reuse a slot freed this cycle
    assign w_drain     = r_stg_vld && !flush && (w_is_epb || !w_fifo_full || w_fifo_pop);
    assign w_fifo_push = w_drain && !w_is_epb;
    assign w_last      = (r_stg_idx == c_idx_w'(IN_BYTES - 1));

    // Input staging register: load a beat, then drain one byte per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stg_data <= '0;
            r_stg_vld  <= 1'b0;
            r_stg_idx  <= '0;
        end else if (flush) begin
            r_stg_vld  <= 1'b0;
            r_stg_idx  <= '0;
        end else if (w_beat_acc) begin
            r_stg_data <= bitstreamFetch;
            r_stg_vld  <= 1'b1;
            r_stg_idx  <= '0;
        end else if (w_drain) begin
            if (w_last) begin
                r_stg_vld <= 1'b0;
                r_stg_idx <= '0;
            end else begin
                r_stg_idx <= r_stg_idx + 1'b1;
            end
        end
    end

    // Zero-run tracking across beats and EPB-removal pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zcnt <= 2'd0;
            r_epb  <= 1'b0;
        end else begin
            r_epb <= w_drain && w_is_epb;
            if (flush) begin
                r_zcnt <= 2'd0;
            end else if (w_drain) begin
                if (w_is_epb || (w_cur_byte != 8'h00)) begin
                    r_zcnt <= 2'd0;
                end else if (r_zcnt != 2'(EPB_ZRUN)) begin
                    r_zcnt <= r_zcnt + 2'd1;
                end
            end
        end
    end

    qdec_bs_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (flush),
        .i_push  (w_fifo_push),
        .i_din   (w_cur_byte),
        .i_pop   (w_fifo_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign bytealign   = (r_pos == 3'd0);
    assign consume_rdy = (c_av_w'(consume_len) <= r_avail);
    // Align wins over consume; flush wins over both
    assign w_align_fire = align_req && !bytealign && !flush;
    assign w_cons_fire  = consume_vld && consume_rdy && !align_req && !flush;

    // Bits removed from the top of the window this cycle
    always_comb begin
        w_shift = '0;
        if (w_align_fire) begin
            w_shift = c_av_w'(4'd8 - {1'b0, r_pos});
        end else if (w_cons_fire) begin
            w_shift = c_av_w'(consume_len);
        end
    end

    assign w_avail_after = r_avail - w_shift;
    assign w_win_after   = r_win << w_shift;
    assign w_fifo_pop    = !w_fifo_empty && !flush && (w_avail_after <= c_av_w'(WIN_BITS - 8));
    // Popped byte lands directly below the bits that survive this cycle's shift
    assign w_refill      = {w_fifo_dout, {(WIN_BITS-8){1'b0}}} >> w_avail_after;

    // Bit window: bits below r_avail are kept zero so the peek needs no masking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win   <= '0;
            r_avail <= '0;
            r_pos   <= 3'd0;
        end else if (flush) begin
            r_win   <= '0;
            r_avail <= '0;
            r_pos   <= 3'd0;
        end else begin
            r_win   <= w_fifo_pop ? (w_win_after | w_refill) : w_win_after;
            r_avail <= w_fifo_pop ? (w_avail_after + c_av_w'(8)) : w_avail_after;
            r_pos   <= r_pos + w_shift[2:0];
        end
    end

    assign bits_peek   = r_win[WIN_BITS-1 -: MAX_BITS];
    assign bits_avail  = r_avail;
    assign epb_dropped = r_epb;

`ifdef QDEC_BS_BYTECNT_EN
    logic [c_av_w:0] w_pos_sum;
    logic [31:0]     r_stream_bytes;
    logic [15:0]     r_epb_count;

    assign w_pos_sum = (c_av_w+1)'(r_pos) + (c_av_w+1)'(w_shift);

    // Byte counters: whole bytes leaving the window and saturating EPB count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stream_bytes <= 32'd0;
            r_epb_count    <= 16'd0;
        end else if (flush) begin
            r_stream_bytes <= 32'd0;
            r_epb_count    <= 16'd0;
        end else begin
            r_stream_bytes <= r_stream_bytes + 32'(w_pos_sum >> 3);
            if (w_drain && w_is_epb && (r_epb_count != 16'hFFFF)) begin
                r_epb_count <= r_epb_count + 16'd1;
            end
        end
    end

    assign stream_bytes = r_stream_bytes;
    assign epb_count    = r_epb_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_qdec_bs_fetch.sv
// ============================================================================
// Module      : tb_qdec_bs_fetch
// Description : Scoreboard bench for qdec_bs_fetch at IN_BYTES=2. Consume
//               requests push expected peek values; a monitor pops and
//               compares whenever a consume is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_qdec_bs_fetch;

    localparam int IN_BYTES   = 2;
    localparam int FIFO_DEPTH = 16;
    localparam int MAX_BITS   = 16;
    localparam int WIN_BITS   = 32;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [15:0] bitstreamFetch;
    logic        bitstreamFetch_vld;
    logic        bitstreamFetch_rdy;
    logic [15:0] bits_peek;
    logic [5:0]  bits_avail;
    logic [4:0]  consume_len;
    logic        consume_vld;
    logic        consume_rdy;
    logic        align_req;
    logic        bytealign;
    logic        epb_dropped;
`ifdef QDEC_BS_BYTECNT_EN
    logic [31:0] stream_bytes;
    logic [15:0] epb_count;
`endif

    qdec_bs_fetch #(
        .IN_BYTES   (IN_BYTES),
        .FIFO_DEPTH (FIFO_DEPTH),
        .MAX_BITS   (MAX_BITS),
        .WIN_BITS   (WIN_BITS)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .flush              (flush),
        .bitstreamFetch     (bitstreamFetch),
        .bitstreamFetch_vld (bitstreamFetch_vld),
        .bitstreamFetch_rdy (bitstreamFetch_rdy),
        .bits_peek          (bits_peek),
        .bits_avail         (bits_avail),
        .consume_len        (consume_len),
        .consume_vld        (consume_vld),
        .consume_rdy        (consume_rdy),
        .align_req          (align_req),
        .bytealign          (bytealign),
        .epb_dropped        (epb_dropped)
`ifdef QDEC_BS_BYTECNT_EN
        ,
        .stream_bytes       (stream_bytes),
        .epb_count          (epb_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          len;
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_epb    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: counts EPB pulses, checks each accepted consume against the scoreboard
    always @(negedge clk) begin
        if (rst_n && epb_dropped) n_epb++;
        if (rst_n && consume_vld && consume_rdy && !align_req && !flush) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_consume: got len %0d with empty scoreboard", consume_len);
            end else begin
                mon_e = sb.pop_front();
                check(mon_e.name, 32'(bits_peek >> (MAX_BITS - mon_e.len)), 32'(mon_e.val));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one beat (b0 earliest) and hold it until accepted
    task automatic send(input logic [7:0] b0, input logic [7:0] b1);
        bit ok;
        int cnt;
        ok  = 1'b0;
        cnt = 0;
        bitstreamFetch     = {b1, b0};
        bitstreamFetch_vld = 1'b1;
        while (!ok && cnt < 3000) begin
            @(negedge clk);
            ok = bitstreamFetch_rdy;
            cnt++;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: beat %02h %02h not accepted, required accept", b0, b1);
        end
        @(posedge clk);
        #1;
        bitstreamFetch_vld = 1'b0;
    endtask

    // Request a consume; the expected peek value goes to the scoreboard first
    task automatic consume(input int len, input logic [15:0] val, input string name);
        bit ok;
        int cnt;
        ok  = 1'b0;
        cnt = 0;
        sb.push_back('{len, val, name});
        consume_len = 5'(len);
        consume_vld = 1'b1;
        while (!ok && cnt < 3000) begin
            @(negedge clk);
            ok = consume_rdy;
            cnt++;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: consume_rdy 0, required 1", name);
        end
        @(posedge clk);
        #1;
        consume_vld = 1'b0;
    endtask

    task automatic do_align();
        align_req = 1'b1;
        @(posedge clk);
        #1;
        align_req = 1'b0;
    endtask

    initial begin
        rst_n              = 1'b0;
        flush              = 1'b0;
        bitstreamFetch     = '0;
        bitstreamFetch_vld = 1'b0;
        consume_len        = 5'd1;
        consume_vld        = 1'b0;
        align_req          = 1'b0;
        idle(3);

        // Reset state
        check("rst_rdy",        32'(bitstreamFetch_rdy), 32'd1);
        check("rst_avail",      32'(bits_avail),         32'd0);
        check("rst_peek",       32'(bits_peek),          32'd0);
        check("rst_consume_rdy",32'(consume_rdy),        32'd0);
        check("rst_bytealign",  32'(bytealign),          32'd1);
        check("rst_epb",        32'(epb_dropped),        32'd0);
        rst_n = 1'b1;
        idle(1);

        // Basic bit window: A5 3C consumed 4,4,8
        send(8'hA5, 8'h3C);
        idle(4);
        check("t1_avail16", 32'(bits_avail), 32'd16);
        check("t1_peek",    32'(bits_peek),  32'hA53C);
        consume(4, 16'hA, "t1_c4a");
        check("t1_avail12", 32'(bits_avail), 32'd12);
        check("t1_ba0",     32'(bytealign),  32'd0);
        consume(4, 16'h5, "t1_c4b");
        check("t1_avail8",  32'(bits_avail), 32'd8);
        check("t1_ba1",     32'(bytealign),  32'd1);
        consume(8, 16'h3C, "t1_c8");
        check("t1_avail0",  32'(bits_avail), 32'd0);

        // 00 00 | 03 01 : EPB straddling a beat boundary is removed
        send(8'h00, 8'h00);
        send(8'h03, 8'h01);
        idle(5);
        check("t2_avail24", 32'(bits_avail), 32'd24);
        check("t2_epb",     32'(n_epb),      32'd1);
        consume(16, 16'h0000, "t2_c16");
        consume(8,  16'h0001, "t2_c8");

        // 00 00 00 03 : zero run saturates, the 03 is still removed
        send(8'h00, 8'h00);
        send(8'h00, 8'h03);
        idle(5);
        check("t3_avail24", 32'(bits_avail), 32'd24);
        check("t3_epb",     32'(n_epb),      32'd2);
        consume(16, 16'h0000, "t3_c16");
        consume(8,  16'h0000, "t3_c8");

        // 00 00 01 03 : 03 after 01 is payload
        send(8'h00, 8'h00);
        send(8'h01, 8'h03);
        idle(5);
        check("t4_avail32", 32'(bits_avail), 32'd32);
        check("t4_epb",     32'(n_epb),      32'd2);
        consume(16, 16'h0000, "t4_c16a");
        consume(16, 16'h0103, "t4_c16b");

        // Consume 3 then align: 5 bits discarded
        send(8'hB7, 8'hE1);
        idle(4);
        consume(3, 16'h5, "t5_c3");
        check("t5_ba0",   32'(bytealign),  32'd0);
        do_align();
        check("t5_ba1",   32'(bytealign),  32'd1);
        check("t5_avail", 32'(bits_avail), 32'd8);
        check("t5_peek",  32'(bits_peek),  32'hE100);
        consume(8, 16'hE1, "t5_c8");

        // Align and consume together: align wins, consume not accepted
        send(8'hC3, 8'h5A);
        idle(4);
        consume(2, 16'h3, "t6_c2");
        consume_len = 5'd4;
        consume_vld = 1'b1;
        align_req   = 1'b1;
        @(posedge clk);
        #1;
        consume_vld = 1'b0;
        align_req   = 1'b0;
        check("t6_avail", 32'(bits_avail), 32'd8);
        check("t6_ba",    32'(bytealign),  32'd1);
        check("t6_peek",  32'(bits_peek),  32'h5A00);
        consume(8, 16'h5A, "t6_c8");

        // Back-pressure: 40 bytes with no consumption, then drain in order
        fork
            begin
                for (int k = 0; k < 20; k++) begin
                    send(8'(2*k + 1), 8'(2*k + 2));
                end
            end
            begin
                idle(60);
                check("t7_rdy_low",  32'(bitstreamFetch_rdy), 32'd0);
                check("t7_avail32",  32'(bits_avail),         32'd32);
                check("t7_peek",     32'(bits_peek),          32'h0102);
                for (int j = 0; j < 20; j++) begin
                    consume(16, {8'(2*j + 1), 8'(2*j + 2)}, $sformatf("t7_c%0d", j));
                end
            end
        join
        idle(2);
        check("t7_avail0", 32'(bits_avail), 32'd0);

        // Flush with buffered data and zcnt at 2
        send(8'h11, 8'h22);
        send(8'h33, 8'h44);
        send(8'h55, 8'h00);
        send(8'h00, 8'h00);
        idle(6);
        check("t8_pre_avail", 32'(bits_avail), 32'd32);
        consume_len        = 5'd1;
        bitstreamFetch     = 16'hAA99;
        bitstreamFetch_vld = 1'b1;
        flush              = 1'b1;
        @(negedge clk);
        check("t8_rdy_flush", 32'(bitstreamFetch_rdy), 32'd0);
        @(posedge clk);
        #1;
        flush              = 1'b0;
        bitstreamFetch_vld = 1'b0;
        check("t8_avail0",   32'(bits_avail),  32'd0);
        check("t8_ba",       32'(bytealign),   32'd1);
        check("t8_crdy",     32'(consume_rdy), 32'd0);
        idle(4);
        check("t8_still0",   32'(bits_avail),  32'd0);
        send(8'h03, 8'h77);
        idle(4);
        check("t8_avail16",  32'(bits_avail),  32'd16);
        check("t8_epb_keep", 32'(n_epb),       32'd2);
        consume(16, 16'h0377, "t8_c0377");
        send(8'h00, 8'h00);
        send(8'h03, 8'hEE);
        idle(5);
        check("t8_avail24",  32'(bits_avail),  32'd24);
        check("t8_epb",      32'(n_epb),       32'd3);
        consume(16, 16'h0000, "t8_c16");
        consume(8,  16'h00EE, "t8_c8");

        idle(2);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
